// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the key conditioner
// Contents:
//   key_state_e : debounce FSM states
//   RW_HOLD_W   : width of the rw hold-window counter
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int RW_HOLD_W = 4;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with synchronous reset
// Ports:
//   clk_i : system clock
//   rst_i : synchronous active-high reset, loads RST_VAL into both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clk edges of latency)
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - push-button debouncer with one-shot key pulse and rw hold
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   key_n     : raw active-low push-button (asynchronous, bouncy)
//   sw_rw     : raw direction switch (asynchronous), 0 = read, 1 = write
//   key       : one-cycle pulse per accepted press
//   rw        : synchronized direction, frozen for RW_HOLD cycles from each pulse
//   pressed   : debounced button level
module key_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RW_HOLD         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    input  logic sw_rw,
    output logic key,
    output logic rw,
    output logic pressed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW_HOLD_W-1:0] HOLD_LOAD = RW_HOLD_W'(RW_HOLD);

    logic key_s;
    logic sw_s;

    // The button is inverted ahead of the synchronizer so a reset value of 0
    // reads as "released".
    sync2 #(.RST_VAL(1'b0)) u_sync_key (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (~key_n),
        .q_o   (key_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sync_sw (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (sw_rw),
        .q_o   (sw_s)
    );

    key_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RW_HOLD_W-1:0] hold_q, hold_d;
    logic                 key_q, key_d;
    logic                 rw_q, rw_d;
    logic                 pressed_q, pressed_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            key_q     <= 1'b0;
            rw_q      <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            key_q     <= key_d;
            rw_q      <= rw_d;
            pressed_q <= pressed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        key_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    key_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                // Holding the button never re-triggers.
                if (!key_s) begin
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed resumes PRESSED silently.
                if (key_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);

        // rw follows the switch only outside the hold window. On the pulse
        // edge the counter is still 0, so rw takes its final value there and
        // then stays frozen while the freshly loaded window runs down.
        rw_d = (hold_q == '0) ? sw_s : rw_q;

        if (key_d) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - RW_HOLD_W'(1);
        end else begin
            hold_d = hold_q;
        end
    end

    assign key     = key_q;
    assign rw      = rw_q;
    assign pressed = pressed_q;

endmodule
